// File: rtl/fifo2axi_pkg.sv
// Shared types and constants for the FIFO-to-AXI4 frame writer.
package fifo2axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [2:0] AXI_SIZE_64    = 3'd3;
  localparam logic [1:0] BRESP_OKAY     = 2'b00;

  function automatic logic [7:0] burst_len(input logic [7:0] rem, input logic [7:0] max_len);
    return (rem < max_len) ? rem : max_len;
  endfunction

endpackage

// File: rtl/fifo2axi_addr_gen.sv
// Frame walker: tracks line base, burst address, beats left in the line and lines left,
// and precomputes the length of the next burst.
module fifo2axi_addr_gen
  import fifo2axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        aw_fire,
  input  logic        advance,
  input  logic [10:0] cfg_img_width,
  input  logic [10:0] cfg_img_height,
  input  logic [10:0] cfg_stride,
  input  logic [31:0] cfg_map_ba,
  input  logic [7:0]  cfg_max_burst_length,
  output logic [31:0] addr,
  output logic [7:0]  awlen,
  output logic        last_burst
);

  logic [31:0] line_base, next_base;
  logic [7:0]  beat_rem, line_beats;
  logic [10:0] line_cnt;

  assign line_beats = 8'(cfg_img_width >> 3);
  assign next_base  = line_base + {21'b0, cfg_stride};
  // Valid in RESP: beat_rem was already reduced when the burst was issued.
  assign last_burst = (beat_rem == 8'd0) && (line_cnt == 11'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      addr      <= '0;
      beat_rem  <= '0;
      line_cnt  <= '0;
      awlen     <= '0;
    end else if (load) begin
      line_base <= cfg_map_ba;
      addr      <= cfg_map_ba;
      line_cnt  <= cfg_img_height;
      beat_rem  <= line_beats;
      awlen     <= burst_len(line_beats, cfg_max_burst_length) - 8'd1;
    end else if (aw_fire) begin
      beat_rem  <= beat_rem - (awlen + 8'd1);
    end else if (advance) begin
      if (beat_rem == 8'd0) begin
        line_base <= next_base;
        addr      <= next_base;
        line_cnt  <= line_cnt - 11'd1;
        beat_rem  <= line_beats;
        awlen     <= burst_len(line_beats, cfg_max_burst_length) - 8'd1;
      end else begin
        addr      <= addr + {21'b0, awlen + 8'd1, 3'b0};
        awlen     <= burst_len(beat_rem, cfg_max_burst_length) - 8'd1;
      end
    end
  end

endmodule

// File: rtl/fifo2axi.sv
// AXI4 write master: drains a first-word-fall-through pixel FIFO into a strided frame
// in memory, one outstanding burst at a time.
module fifo2axi
  import fifo2axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  awready,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [1:0]            awburst,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  wready,
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  input  logic                  cfg_blk_en,
  input  logic [10:0]           cfg_img_width,
  input  logic [10:0]           cfg_img_height,
  input  logic [10:0]           cfg_stride,
  input  logic [31:0]           cfg_map_ba,
  input  logic [7:0]            cfg_max_burst_length,
  input  logic                  cfg_reverse_pixel,
  input  logic [ADDR_WIDTH-1:0] fifo_words_used,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [63:0]           fifo_data,
  output logic                  fifo_pop,
  output logic                  sts_done,
  output logic                  sts_err
);

  state_e      state, state_nxt;
  logic        blk_en_d, start, load, aw_fire, w_fire, b_fire, last_burst;
  logic [7:0]  beat_cnt;
  logic [8:0]  occ;
  logic [63:0] data_rev;

  assign start   = cfg_blk_en & ~blk_en_d;
  assign load    = (state == ST_IDLE) && start;
  assign occ     = 9'({fifo_full, fifo_words_used});
  assign awburst = AXI_BURST_INCR;
  assign awsize  = AXI_SIZE_64;
  assign wstrb   = 8'hFF;

  fifo2axi_addr_gen u_addr_gen (
    .clk                  (clk),
    .rst_n                (rst_n),
    .load                 (load),
    .aw_fire              (aw_fire),
    .advance              (b_fire),
    .cfg_img_width        (cfg_img_width),
    .cfg_img_height       (cfg_img_height),
    .cfg_stride           (cfg_stride),
    .cfg_map_ba           (cfg_map_ba),
    .cfg_max_burst_length (cfg_max_burst_length),
    .addr                 (awaddr),
    .awlen                (awlen),
    .last_burst           (last_burst)
  );

  // Only this block pops the FIFO, so occupancy cannot fall while awvalid is high.
  assign awvalid = (state == ST_ADDR) && (occ >= 9'(awlen) + 9'd1);
  assign aw_fire = awvalid & awready;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_rev
      assign data_rev[8*i +: 8] = fifo_data[8*(7-i) +: 8];
    end
  endgenerate

  assign wvalid   = (state == ST_DATA) & ~fifo_empty;
  assign wdata    = (state != ST_DATA) ? 64'd0 : (cfg_reverse_pixel ? data_rev : fifo_data);
  assign wlast    = (state == ST_DATA) && (beat_cnt == awlen);
  assign w_fire   = wvalid & wready;
  assign fifo_pop = w_fire;
  assign bready   = (state == ST_RESP);
  assign b_fire   = bvalid & bready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start)           state_nxt = ST_ADDR;
      ST_ADDR: if (aw_fire)         state_nxt = ST_DATA;
      ST_DATA: if (w_fire && wlast) state_nxt = ST_RESP;
      ST_RESP: if (b_fire)          state_nxt = (last_burst || !cfg_blk_en) ? ST_IDLE : ST_ADDR;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      blk_en_d <= 1'b0;
      beat_cnt <= '0;
      sts_done <= 1'b0;
      sts_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      blk_en_d <= cfg_blk_en;
      if (aw_fire)     beat_cnt <= '0;
      else if (w_fire) beat_cnt <= beat_cnt + 8'd1;
      if (load) begin
        sts_done <= 1'b0;
        sts_err  <= 1'b0;
      end else if (b_fire) begin
        if (bresp != BRESP_OKAY) sts_err  <= 1'b1;
        if (last_burst)          sts_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo2axi.sv
// Bench for fifo2axi: FIFO and AXI slave models with random stalls, checked against a
// burst list derived from the frame geometry.
module tb_fifo2axi;
  localparam int AW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        awready = 0, wready = 0, bvalid = 0;
  logic [1:0]  bresp = 0;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [2:0]  awsize;
  logic        awvalid, wlast, wvalid, bready, fifo_pop, sts_done, sts_err;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        cfg_blk_en = 0, cfg_reverse_pixel = 0;
  logic [10:0] cfg_img_width = 0, cfg_img_height = 0, cfg_stride = 0;
  logic [31:0] cfg_map_ba = 0;
  logic [7:0]  cfg_max_burst_length = 0;
  logic [AW-1:0] fifo_words_used = 0;
  logic        fifo_full = 0, fifo_empty = 1;
  logic [63:0] fifo_data = 0;

  fifo2axi #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awburst(awburst), .awsize(awsize), .awvalid(awvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .bvalid(bvalid), .bresp(bresp),
    .bready(bready), .cfg_blk_en(cfg_blk_en), .cfg_img_width(cfg_img_width),
    .cfg_img_height(cfg_img_height), .cfg_stride(cfg_stride), .cfg_map_ba(cfg_map_ba),
    .cfg_max_burst_length(cfg_max_burst_length), .cfg_reverse_pixel(cfg_reverse_pixel),
    .fifo_words_used(fifo_words_used), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .sts_done(sts_done), .sts_err(sts_err)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;

  int          n_tests = 0, n_fail = 0;
  logic [63:0] fq[$];
  burst_t      exp_b[$];
  logic [31:0] seen_aw[$];
  int          stall_pct, push_pct, hold_cyc, err_burst, target, produced;
  int          cyc_cnt, first_aw, n_bursts, n_pops, n_b, beat;
  bit          drop_mode, drop_pending, dropped, special, b_owed, in_burst;
  bit          prev_aw_wait, prev_w_wait;
  logic [31:0] prev_awaddr;
  logic [7:0]  prev_awlen, cur_len;
  logic [63:0] prev_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] byte_swap(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] next_word();
    if (special) begin special = 0; return 64'h0102030405060708; end
    return {$urandom, $urandom};
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 64'hDEAD_BEEF_DEAD_BEEF;
    {fifo_full, fifo_words_used} = 6'(fq.size());
  endtask

  task automatic monitor();
    logic aw_hs, w_hs, b_hs;
    aw_hs = awvalid & awready;
    w_hs  = wvalid & wready;
    b_hs  = bvalid & bready;
    if (prev_aw_wait) begin
      chk("awvalid_hold", awvalid, 1);
      chk("awaddr_hold", awaddr, prev_awaddr);
      chk("awlen_hold", awlen, prev_awlen);
    end
    if (prev_w_wait) chk("wdata_hold", wdata, prev_wdata);
    if (awvalid) begin
      chk("aw_occupancy", fq.size() >= int'(awlen) + 1, 1);
      if (first_aw < 0) first_aw = cyc_cnt;
    end
    chk(in_burst ? "w_no_gap" : "w_outside_burst", wvalid, in_burst);
    if (cyc_cnt == 1) begin
      chk("start_clr_done", sts_done, 0);
      chk("start_clr_err", sts_err, 0);
    end
    if (aw_hs) begin
      chk("aw_expected", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        chk("awaddr", awaddr, exp_b[0].addr);
        chk("awlen", awlen, exp_b[0].len);
        cur_len = exp_b[0].len;
        void'(exp_b.pop_front());
      end
      seen_aw.push_back(awaddr);
      n_bursts++;
      beat = 0;
      in_burst = 1;
    end
    chk("fifo_pop", fifo_pop, w_hs);
    if (w_hs) begin
      chk("wdata", wdata, cfg_reverse_pixel ? byte_swap(fq[0]) : fq[0]);
      if (cfg_reverse_pixel && fq[0] == 64'h0102030405060708)
        chk("wdata_reverse_const", wdata, 64'h0807060504030201);
      chk("wlast", wlast, beat == int'(cur_len));
      if (drop_mode && !dropped) begin drop_pending = 1; dropped = 1; end
      n_pops++;
      beat++;
      if (wlast) begin in_burst = 0; b_owed = 1; end
    end
    if (b_hs) begin b_owed = 0; n_b++; end
    prev_aw_wait = awvalid & ~awready;
    prev_w_wait  = wvalid & ~wready;
    prev_awaddr  = awaddr;
    prev_awlen   = awlen;
    prev_wdata   = wdata;
  endtask

  task automatic cyc();
    bit pop_now;
    @(negedge clk);
    monitor();
    pop_now = fifo_pop;
    @(posedge clk); #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    cyc_cnt++;
    if (drop_pending) begin cfg_blk_en = 0; drop_pending = 0; end
    if (cyc_cnt >= hold_cyc && fq.size() < 32 && produced < target && $urandom_range(99) < push_pct) begin
      fq.push_back(next_word());
      produced++;
    end
    awready = ($urandom_range(99) >= stall_pct);
    wready  = ($urandom_range(99) >= stall_pct);
    bvalid  = b_owed && ($urandom_range(99) >= stall_pct);
    bresp   = (n_b == err_burst) ? 2'b10 : 2'b00;
    drive_fifo();
  endtask

  task automatic run_frame(input int w, input int h, input int stride, input logic [31:0] ba,
                           input int mb, input bit rev, input int prefill, input int stall,
                           input int push, input int hold, input int errb, input bit drop);
    logic [31:0] a;
    int rem, n, words, nb;
    cfg_blk_en = 0;
    cyc();
    exp_b.delete();
    seen_aw.delete();
    for (int l = 0; l < h; l++) begin
      a = ba + 32'(l * stride);
      rem = w / 8;
      while (rem > 0) begin
        n = (rem < mb) ? rem : mb;
        exp_b.push_back('{a, 8'(n - 1)});
        a += 32'(n * 8);
        rem -= n;
      end
    end
    nb = exp_b.size();
    words = (w / 8) * h;
    cfg_img_width = 11'(w); cfg_img_height = 11'(h); cfg_stride = 11'(stride);
    cfg_map_ba = ba; cfg_max_burst_length = 8'(mb); cfg_reverse_pixel = rev;
    stall_pct = stall; push_pct = push; hold_cyc = hold; err_burst = errb;
    drop_mode = drop; dropped = 0; drop_pending = 0;
    target = (words > fq.size()) ? words - fq.size() : 0;
    produced = 0;
    for (int i = 0; i < prefill && produced < target && fq.size() < 32; i++) begin
      fq.push_back(next_word());
      produced++;
    end
    cyc_cnt = 0; first_aw = -1; n_bursts = 0; n_pops = 0; n_b = 0;
    if (fq.size() >= int'(exp_b[0].len) + 1) n = 1; else n = 0;
    drive_fifo();
    cfg_blk_en = 1;
    if (drop) begin
      for (int i = 0; i < 4000; i++) begin
        cyc();
        if (n_b >= 1 && !cfg_blk_en) break;
      end
      repeat (5) cyc();
      chk("drop_b_count", n_b, 1);
      chk("drop_bursts", n_bursts, 1);
      chk("drop_done", sts_done, 0);
      chk("drop_idle_awvalid", awvalid, 0);
    end else begin
      for (int i = 0; i < 4000; i++) begin
        cyc();
        if (i > 1 && sts_done === 1'b1) break;
      end
      chk("frame_done", sts_done, 1);
      chk("bursts_left", exp_b.size(), 0);
      chk("burst_count", n_bursts, nb);
      chk("pop_count", n_pops, words);
      chk("sts_err", sts_err, (errb >= 0 && errb < nb) ? 1 : 0);
      if (n == 1) chk("aw_latency", first_aw, 1);
    end
  endtask

  initial begin
    cyc_cnt = 99; hold_cyc = 0; push_pct = 0; stall_pct = 0; err_burst = -1;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_bready", bready, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_sts_done", sts_done, 0);
    chk("rst_sts_err", sts_err, 0);
    chk("rst_awburst", awburst, 2'd1);
    chk("rst_awsize", awsize, 3'd3);
    chk("rst_wstrb", wstrb, 8'hFF);
    @(posedge clk); #1;
    rst_n = 1;

    // 64x2 frame, prefilled FIFO, slave always ready
    run_frame(64, 2, 128, 32'h1000, 4, 0, 16, 0, 100, 0, -1, 0);
    chk("a_bursts", n_bursts, 4);
    chk("a_pops", n_pops, 16);
    if (seen_aw.size() == 4) begin
      chk("a_aw0", seen_aw[0], 32'h1000);
      chk("a_aw1", seen_aw[1], 32'h1020);
      chk("a_aw2", seen_aw[2], 32'h1080);
      chk("a_aw3", seen_aw[3], 32'h10A0);
    end

    // width 40: 4-beat then 1-beat burst per line
    run_frame(40, 3, 64, 32'h2000, 4, 0, 16, 0, 100, 0, -1, 0);
    if (seen_aw.size() > 1) chk("w40_aw1", seen_aw[1], 32'h2020);

    // FIFO holds 2 words, burst needs 4: address phase must wait
    run_frame(64, 1, 64, 32'h3000, 4, 0, 2, 0, 100, 20, -1, 0);
    chk("starve_wait", first_aw >= 20, 1);

    // random geometry with random stalls on every channel
    for (int k = 0; k < 4; k++)
      run_frame(8 * $urandom_range(1, 40), $urandom_range(1, 4), 0 + 8 * $urandom_range(41, 60),
                $urandom & 32'hFFFF_FFF8, $urandom_range(1, 16), 1'($urandom_range(1)),
                0, 30, 60, 0, -1, 0);

    // byte reversal with a known head word
    special = 1;
    run_frame(16, 2, 32, 32'h4000, 2, 1, 4, 10, 100, 0, -1, 0);

    // error response on the third burst, then cleared by the next start
    run_frame(64, 2, 128, 32'h5000, 4, 0, 0, 20, 70, 0, 2, 0);
    run_frame(32, 1, 32, 32'h5800, 4, 0, 4, 0, 100, 0, -1, 0);

    // disable mid-burst, then re-enable from the base address
    run_frame(64, 2, 128, 32'h6000, 4, 0, 16, 20, 100, 0, -1, 1);
    run_frame(64, 2, 128, 32'h6000, 4, 0, 16, 20, 100, 0, -1, 0);

    // address wrap modulo 2^32
    run_frame(32, 2, 64, 32'hFFFF_FFF0, 4, 0, 8, 0, 100, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
